cursor_anim: RTL and testbench

Parametrised grid-cursor overlay for the video pipeline. It renders a bitmap cursor sprite on a selectable grid cell and slides it smoothly between cells over successive frames instead of jumping. It also blinks when a selection is locked. The block sits beside the board renderers, is fed by the shared `hcnt`/`vcnt` raster counters, and drives an RGB layer that the mixer ORs or overlays onto the board.

---
 rtl/cursor_anim.sv | 168 ++++++++++++++++
 tb/tb_cursor_anim.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_anim.sv
// Grid-cursor overlay: draws a ROM sprite at the cursor's pixel position and slides it between
// grid cells a bounded step per frame. It blinks while the selection is locked.
module cursor_anim #(
  parameter int unsigned HBLANK     = 700,
  parameter int unsigned VBLANK     = 536,
  parameter int unsigned PITCH      = 160,
  parameter int unsigned COORD_W    = 2,
  parameter int unsigned SPR_AX     = 6,
  parameter int unsigned SPR_AY     = 3,
  parameter int unsigned SCALE      = 1,
  parameter int unsigned STEP       = 8,
  parameter int unsigned BLINK_LOG2 = 5,
  parameter logic [23:0] FG_RGB     = 24'hFF7B5D,
  parameter logic [23:0] BG_RGB     = 24'h556735
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [11:0]              hcnt,
  input  logic [10:0]              vcnt,
  input  logic                     frame_start,
  input  logic [COORD_W-1:0]       xcoord,
  input  logic [COORD_W-1:0]       ycoord,
  input  logic                     locked,
  output logic [SPR_AY+SPR_AX-1:0] rom_addr,
  input  logic                     rom_q,
  output logic                     busy,
  output logic                     pix_valid,
  output logic [7:0]               cursorr,
  output logic [7:0]               cursorg,
  output logic [7:0]               cursorb
);

  localparam int unsigned SprW = 1 << (SPR_AX + SCALE);
  localparam int unsigned SprH = 1 << (SPR_AY + SCALE);

  typedef enum logic [0:0] {StIdle, StMove} state_e;

  state_e      state_q, state_d;
  logic [11:0] posx_q, posx_d, tgtx_q, tgtx_new;
  logic [10:0] posy_q, posy_d, tgty_q, tgty_new;

  // Move one axis toward its target by at most STEP, never overshooting.
  function automatic logic [11:0] step_toward(input logic [11:0] pos, input logic [11:0] tgt);
    logic [11:0] diff;
    if (tgt > pos) begin
      diff = tgt - pos;
      return pos + ((diff < 12'(STEP)) ? diff : 12'(STEP));
    end else begin
      diff = pos - tgt;
      return pos - ((diff < 12'(STEP)) ? diff : 12'(STEP));
    end
  endfunction

  assign tgtx_new = 12'(xcoord) * 12'(PITCH);
  assign tgty_new = 11'(ycoord) * 11'(PITCH);

  always_comb begin
    posx_d = posx_q;
    posy_d = posy_q;
    if (frame_start) begin
      posx_d = step_toward(posx_q, tgtx_new);
      posy_d = 11'(step_toward({1'b0, posy_q}, {1'b0, tgty_new}));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      posx_q <= '0;
      posy_q <= '0;
      tgtx_q <= '0;
      tgty_q <= '0;
    end else begin
      posx_q <= posx_d;
      posy_q <= posy_d;
      if (frame_start) begin
        tgtx_q <= tgtx_new;
        tgty_q <= tgty_new;
      end
    end
  end

  // Motion FSM: state register, next state, output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = (posx_d != tgtx_new || posy_d != tgty_new) ? StMove : StIdle;
    end
  end

  always_comb begin
    busy = (state_q == StMove);
  end

  motion_state_consistent: assert property (@(posedge clk) disable iff (!reset)
    (state_q == StMove) == (posx_q != tgtx_q || posy_q != tgty_q));

  // Blink counter; a rising edge of locked restarts the period and beats the frame increment.
  logic                  locked_q;
  logic [BLINK_LOG2-1:0] bcnt_q;
  logic                  vis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_q <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      locked_q <= locked;
      if (locked && !locked_q) bcnt_q <= '0;
      else if (frame_start)    bcnt_q <= bcnt_q + 1'b1;
    end
  end

  assign vis = !locked || !bcnt_q[BLINK_LOG2-1];

  // Window test in one extra bit so the upper bound cannot wrap.
  logic [11:0] hd;
  logic [10:0] vd;
  logic [12:0] hlo, hhi;
  logic [11:0] vlo, vhi;
  logic        in_win;
  logic        unused_bits;

  assign hd  = hcnt - 12'(HBLANK) - posx_q;
  assign vd  = vcnt - 11'(VBLANK) - posy_q;
  assign hlo = 13'(HBLANK) + {1'b0, posx_q};
  assign hhi = hlo + 13'(SprW);
  assign vlo = 12'(VBLANK) + {1'b0, posy_q};
  assign vhi = vlo + 12'(SprH);

  assign in_win = ({1'b0, hcnt} >= hlo) && ({1'b0, hcnt} < hhi) &&
                  ({1'b0, vcnt} >= vlo) && ({1'b0, vcnt} < vhi);

  assign rom_addr    = {vd[SPR_AY+SCALE-1 -: SPR_AY], hd[SPR_AX+SCALE-1 -: SPR_AX]};
  assign unused_bits = ^{hd, vd};

  // Stage 1 lines the select up with the ROM data; stage 2 registers the colour.
  logic        sel_q;
  logic [23:0] rgb_d, rgb_q;
  logic        valid_q;

  always_comb begin
    rgb_d = 24'h0;
    if (sel_q) rgb_d = rom_q ? BG_RGB : FG_RGB;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= 1'b0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= in_win && vis;
      rgb_q   <= rgb_d;
      valid_q <= sel_q;
    end
  end

  assign cursorr   = rgb_q[23:16];
  assign cursorg   = rgb_q[15:8];
  assign cursorb   = rgb_q[7:0];
  assign pix_valid = valid_q;

endmodule

// File: tb/tb_cursor_anim.sv
// Directed bench for cursor_anim: default instance plus a swept-parameter instance
// (COORD_W=3, PITCH=96, SCALE=0, STEP=5) sharing clock, reset, raster and frame pulses.
module tb_cursor_anim;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] hcnt = '0;
  logic [10:0] vcnt = '0;
  logic        frame_start = 1'b0;
  logic        locked = 1'b0;

  logic [1:0]  xcoord = '0, ycoord = '0;
  logic [8:0]  rom_addr;
  logic        rom_q = 1'b0;
  logic        busy, pix_valid;
  logic [7:0]  cursorr, cursorg, cursorb;

  logic [2:0]  xcoord2 = '0, ycoord2 = '0;
  logic [8:0]  rom_addr2;
  logic        rom_q2 = 1'b0;
  logic        busy2, pix_valid2;
  logic [7:0]  cursorr2, cursorg2, cursorb2;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] Fg = 32'hFF7B5D;
  localparam logic [31:0] Bg = 32'h556735;

  always #5 clk = ~clk;

  cursor_anim dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .frame_start(frame_start),
    .xcoord(xcoord), .ycoord(ycoord), .locked(locked), .rom_addr(rom_addr), .rom_q(rom_q),
    .busy(busy), .pix_valid(pix_valid), .cursorr(cursorr), .cursorg(cursorg), .cursorb(cursorb)
  );

  cursor_anim #(.COORD_W(3), .PITCH(96), .SCALE(0), .STEP(5)) dut2 (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .frame_start(frame_start),
    .xcoord(xcoord2), .ycoord(ycoord2), .locked(locked), .rom_addr(rom_addr2), .rom_q(rom_q2),
    .busy(busy2), .pix_valid(pix_valid2), .cursorr(cursorr2), .cursorg(cursorg2),
    .cursorb(cursorb2)
  );

  // Sprite ROM model: checkerboard of column bit 0 xor row bit 0, one cycle latency.
  always @(posedge clk) begin
    rom_q  <= rom_addr[0] ^ rom_addr[6];
    rom_q2 <= rom_addr2[0] ^ rom_addr2[6];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic raster(input int h, input int v);
    hcnt = 12'(h);
    vcnt = 11'(v);
    tick();
    tick();
  endtask

  function automatic logic [31:0] exp_rgb(input bit valid, input bit b);
    if (!valid) return 32'h0;
    return b ? Bg : Fg;
  endfunction

  // Default instance: SCALE=1, so column/row bit 0 are offset bit 1.
  task automatic pix1(input string tag, input int h, input int v, input int px, input int py,
                      input bit valid);
    logic [11:0] hd;
    logic [10:0] vd;
    hd = 12'(h - 700 - px);
    vd = 11'(v - 536 - py);
    raster(h, v);
    check({tag, "_valid"}, {31'b0, pix_valid}, {31'b0, valid});
    check({tag, "_rgb"}, {8'h0, cursorr, cursorg, cursorb}, exp_rgb(valid, hd[1] ^ vd[1]));
  endtask

  // Swept instance: SCALE=0, so column/row bit 0 are offset bit 0.
  task automatic pix2(input string tag, input int h, input int v, input int px, input bit valid);
    logic [11:0] hd;
    logic [10:0] vd;
    hd = 12'(h - 700 - px);
    vd = 11'(v - 536);
    raster(h, v);
    check({tag, "_valid"}, {31'b0, pix_valid2}, {31'b0, valid});
    check({tag, "_rgb"}, {8'h0, cursorr2, cursorg2, cursorb2}, exp_rgb(valid, hd[0] ^ vd[0]));
  endtask

  initial begin
    // 1. Reset and static cursor
    #23;
    check("rst_rgb", {8'h0, cursorr, cursorg, cursorb}, 32'h0);
    check("rst_valid", {31'b0, pix_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b1;
    tick();
    hcnt = 12'd710;
    vcnt = 11'd542;
    #1;
    check("rom_addr", {23'b0, rom_addr}, 32'd197);
    pix1("origin", 700, 536, 0, 0, 1'b1);
    pix1("col1", 702, 536, 0, 0, 1'b1);
    pix1("last_col", 827, 536, 0, 0, 1'b1);
    pix1("past_col", 828, 536, 0, 0, 1'b0);
    pix1("pre_col", 699, 536, 0, 0, 1'b0);
    pix1("past_row", 700, 552, 0, 0, 1'b0);
    pix2("s_origin", 700, 536, 0, 1'b1);
    pix2("s_last_col", 763, 536, 0, 1'b1);
    pix2("s_past_col", 764, 536, 0, 1'b0);
    hcnt = '0;
    vcnt = '0;

    // 2. One-cell move
    xcoord = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      pulse();
      check("mv_posx", {20'b0, dut.posx_q}, 32'(8 * k));
      check("mv_busy", {31'b0, busy}, {31'b0, k < 20});
    end
    pix1("cell1_first", 860, 536, 160, 0, 1'b1);
    pix1("cell1_pre", 859, 536, 160, 0, 1'b0);
    pix1("cell1_last", 987, 536, 160, 0, 1'b1);
    pix1("cell1_past", 988, 536, 160, 0, 1'b0);

    // 3. Return, retarget mid-move, diagonal
    xcoord = 2'd0;
    for (int k = 1; k <= 20; k++) begin
      pulse();
      check("back_posx", {20'b0, dut.posx_q}, 32'(160 - 8 * k));
      check("back_busy", {31'b0, busy}, {31'b0, k < 20});
    end
    xcoord = 2'd1;
    for (int k = 1; k <= 10; k++) pulse();
    check("half_posx", {20'b0, dut.posx_q}, 32'd80);
    xcoord = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      pulse();
      check("rt_posx", {20'b0, dut.posx_q}, (k < 10) ? 32'(80 - 8 * k) : 32'd0);
      check("rt_busy", {31'b0, busy}, {31'b0, k < 10});
    end
    xcoord = 2'd3;
    ycoord = 2'd3;
    for (int k = 1; k <= 60; k++) begin
      pulse();
      check("dg_posx", {20'b0, dut.posx_q}, 32'(8 * k));
      check("dg_posy", {21'b0, dut.posy_q}, 32'(8 * k));
      check("dg_busy", {31'b0, busy}, {31'b0, k < 60});
    end
    pix1("cell33", 1180, 1016, 480, 480, 1'b1);
    pix1("cell33_pre", 1179, 1016, 480, 480, 1'b0);
    xcoord = 2'd0;
    ycoord = 2'd0;
    for (int k = 1; k <= 60; k++) pulse();
    check("home_posx", {20'b0, dut.posx_q}, 32'd0);
    check("home_posy", {21'b0, dut.posy_q}, 32'd0);
    check("home_busy", {31'b0, busy}, 32'd0);

    // 4. Blink
    locked = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      pix1("blink", 700, 536, 0, 0, k < 16);
      pulse();
    end
    pix1("blink_wrap", 700, 536, 0, 0, 1'b1);
    for (int k = 0; k < 16; k++) pulse();
    pix1("blink_off", 700, 536, 0, 0, 1'b0);
    locked = 1'b0;
    pix1("unlock", 700, 536, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) pulse();
    locked = 1'b1;
    pulse();
    check("coinc_bcnt", {27'b0, dut.bcnt_q}, 32'd0);
    pix1("coinc_vis", 700, 536, 0, 0, 1'b1);
    for (int k = 0; k < 16; k++) pulse();
    pix1("coinc_off", 700, 536, 0, 0, 1'b0);
    locked = 1'b0;
    hcnt = '0;

    // 5. Reset mid-move
    xcoord = 2'd1;
    for (int k = 1; k <= 6; k++) pulse();
    check("pre_rst_posx", {20'b0, dut.posx_q}, 32'd48);
    pix1("pre_rst_pix", 748, 536, 48, 0, 1'b1);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {31'b0, pix_valid}, 32'd0);
    check("async_rgb", {8'h0, cursorr, cursorg, cursorb}, 32'h0);
    check("async_busy", {31'b0, busy}, 32'd0);
    #14 reset = 1'b1;
    tick();
    check("post_rst_posx", {20'b0, dut.posx_q}, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    xcoord = 2'd0;
    hcnt = '0;

    // 6. Swept instance: partial final step
    xcoord2 = 3'd1;
    for (int k = 1; k <= 21; k++) begin
      pulse();
      check("sw_posx", {20'b0, dut2.posx_q}, (5 * k < 96) ? 32'(5 * k) : 32'd96);
      check("sw_busy", {31'b0, busy2}, {31'b0, k < 20});
    end
    pix2("s_cell1", 796, 536, 96, 1'b1);
    pix2("s_cell1_pre", 795, 536, 96, 1'b0);
    pix2("s_cell1_last", 859, 536, 96, 1'b1);
    pix2("s_cell1_past", 860, 536, 96, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
